// File: rtl/uart_tx_byte_if.sv
// Byte-request and serial-line bundle for uart_tx_byte.
// The producer drives I/VALID; the transmitter drives READY/TX/BUSY.
interface uart_tx_byte_if;
    logic [7:0] I;
    logic       VALID;
    logic       READY;
    logic       TX;
    logic       BUSY;

    modport master (
        output I,
        output VALID,
        input  READY,
        input  TX,
        input  BUSY
    );

    modport slave (
        input  I,
        input  VALID,
        output READY,
        output TX,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter, LSB first: one byte per VALID&READY handshake.
// TX, READY and BUSY come straight from flops; all timing is BAUD_DIV cycles per bit.
module uart_tx_byte #(
    parameter int BAUD_DIV = 104,
    parameter int CNT_W    = 16
) (
    input  logic           CLK,
    input  logic           RESETN,
    uart_tx_byte_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             tx_r, tx_s;
    logic             ready_r, ready_s;
    logic             busy_r;
    logic             tc_s;

    assign tc_s = (cnt_r == TC_VAL);

    // Next-state logic; tx_s/ready_s are the values the output flops take next cycle.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        ready_s   = ready_r;
        case (state_r)
            ST_IDLE: begin
                tx_s    = 1'b1;
                ready_s = 1'b1;
                if (bus.VALID && ready_r) begin
                    shift_s = bus.I;
                    cnt_s   = '0;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                    ready_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                ready_s = 1'b0;
                if (tc_s) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                    tx_s      = shift_r[0];
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    tx_s  = 1'b0;
                end
            end
            ST_DATA: begin
                ready_s = 1'b0;
                if (tc_s) begin
                    cnt_s     = '0;
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    // Look ahead one bit so TX changes on the same edge as the bit index.
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        tx_s = shift_r[1];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    tx_s  = shift_r[0];
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (tc_s) begin
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    ready_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = '0;
                bit_idx_s = 3'd0;
                tx_s      = 1'b1;
                ready_s   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
            ready_r   <= ready_s;
            busy_r    <= ~ready_s;
        end
    end

    assign bus.TX    = tx_r;
    assign bus.READY = ready_r;
    assign bus.BUSY  = busy_r;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: a BAUD_DIV=4 and a BAUD_DIV=2 instance share stimulus;
// a frame-position model is compared every cycle, plus hand-computed waveform checks.
module tb_uart_tx_byte;

    logic       clk = 1'b0;
    logic       resetn;
    logic       valid;
    logic [7:0] din;

    always #5 clk = ~clk;

    uart_tx_byte_if if4 ();
    uart_tx_byte_if if2 ();

    assign if4.I     = din;
    assign if4.VALID = valid;
    assign if2.I     = din;
    assign if2.VALID = valid;

    uart_tx_byte #(.BAUD_DIV(4), .CNT_W(16)) dut4 (.CLK(clk), .RESETN(resetn), .bus(if4));
    uart_tx_byte #(.BAUD_DIV(2), .CNT_W(16)) dut2 (.CLK(clk), .RESETN(resetn), .bus(if2));

    // Model: per DUT, whether a frame is in flight, the cycle offset into it, and its byte.
    bit         m_busy [2] = '{1'b0, 1'b0};
    int         m_pos  [2] = '{0, 0};
    logic [7:0] m_byte [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    function automatic int bd(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // Expected line level: start bit, 8 data bits LSB first, stop bit, each d cycles long.
    function automatic logic exp_tx(input bit busy, input int pos, input logic [7:0] b, input int d);
        if (!busy)       return 1'b1;
        if (pos < d)     return 1'b0;
        if (pos < 9 * d) return b[(pos - d) / d];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_busy[k] <= 1'b0;
                m_pos[k]  <= 0;
            end else if (!m_busy[k]) begin
                if (valid) begin
                    m_busy[k] <= 1'b1;
                    m_pos[k]  <= 0;
                    m_byte[k] <= din;
                end
            end else if (m_pos[k] == 10 * bd(k) - 1) begin
                m_busy[k] <= 1'b0;
            end else begin
                m_pos[k] <= m_pos[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare both DUTs against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            check("tx_div4",    if4.TX,    exp_tx(m_busy[0], m_pos[0], m_byte[0], 4));
            check("ready_div4", if4.READY, ~m_busy[0]);
            check("busy_div4",  if4.BUSY,  m_busy[0]);
            check("tx_div2",    if2.TX,    exp_tx(m_busy[1], m_pos[1], m_byte[1], 2));
            check("ready_div2", if2.READY, ~m_busy[1]);
            check("busy_div2",  if2.BUSY,  m_busy[1]);
        end
    endtask

    task automatic send(input logic [7:0] b);
        din   = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
        din   = ~b;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (if4.READY === 1'b1 && if2.READY === 1'b1) done = 1'b1;
            else step();
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: READY still low after 300 cycles");
        end
    endtask

    initial begin
        logic [9:0] a5_frame;
        int lows;
        a5_frame = 10'b1_10100101_0;

        // Reset held with VALID high: reset wins, line idles.
        resetn = 1'b0;
        valid  = 1'b1;
        din    = 8'hC3;
        chk_en = 1'b1;
        repeat (3) step();
        check("rst_tx",    if4.TX,    1'b1);
        check("rst_ready", if4.READY, 1'b1);
        check("rst_busy",  if4.BUSY,  1'b0);
        valid  = 1'b0;
        resetn = 1'b1;
        repeat (5) step();
        check("post_rst_ready", if4.READY, 1'b1);

        // 8'hA5 at BAUD_DIV=4 against a hand-written frame.
        send(8'hA5);
        for (int c = 0; c <= 40; c++) begin
            if (c < 40) check("a5_tx", if4.TX, a5_frame[c / 4]);
            check("a5_ready", if4.READY, (c == 40) ? 1'b1 : 1'b0);
            if (c < 40) step();
        end
        wait_idle();

        // VALID held: 8'h01 then 8'hFF back to back.
        din   = 8'h01;
        valid = 1'b1;
        step();
        din = 8'hFF;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (c == 40) check("b2b_ready", if4.READY, 1'b1);
            if (c == 41) begin
                check("b2b_start", if4.TX, 1'b0);
                valid = 1'b0;
            end
            if (c == 45) check("b2b_ff_bit0", if4.TX, 1'b1);
        end
        wait_idle();

        // VALID pulse mid-frame is ignored.
        send(8'h00);
        repeat (10) step();
        check("ign_ready", if4.READY, 1'b0);
        din   = 8'h3C;
        valid = 1'b1;
        step();
        valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 aborts the frame.
        send(8'h00);
        repeat (17) step();
        check("mid_tx", if4.TX, 1'b0);
        resetn = 1'b0;
        step();
        check("abort_tx",    if4.TX,    1'b1);
        check("abort_ready", if4.READY, 1'b1);
        resetn = 1'b1;
        step();
        send(8'h55);
        wait_idle();

        // BAUD_DIV=2, 8'h80: 16 low cycles then 4 high, 20-cycle frame.
        send(8'h80);
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            if (if2.TX === 1'b0) lows++;
            check("div2_busy", if2.READY, 1'b0);
            step();
        end
        check_int("div2_low_cycles", lows, 16);
        check("div2_ready", if2.READY, 1'b1);
        wait_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
